// File: rtl/btn_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | btn_pkg : shared types, state encodings and helpers for the      |
// |           multi-channel button debounce bank                     |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
package btn_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DELAY  = 2'd1;
  localparam logic [1:0] REPEAT = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = IDLE,
    S_DELAY  = DELAY,
    S_REPEAT = REPEAT
  } rep_state_t;

  // Bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic int tick_div(input int f_clk, input int tick_us);
    return (f_clk / 1_000_000) * tick_us;
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce_bank_ch.sv
`default_nettype none
// +------------------------------------------------------------------+
// | debounce_ch : one button channel - synchroniser, tick-driven     |
// |               integrator, edge strobes and auto-repeat FSM       |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
module debounce_ch
  import btn_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int HOLD_T       = 20,
  parameter int REP_DELAY_T  = 500,
  parameter int REP_PERIOD_T = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_btn,
  input  logic             i_rep_en,
  input  logic             i_tick,
  output logic             o_level,
  output logic             o_rise,
  output logic             o_fall,
  output logic             o_rep,
  output logic [CNT_W-1:0] o_xf
);

  localparam logic [CNT_W-1:0] C_HOLD_LAST   = CNT_W'(HOLD_T - 1);
  localparam logic [CNT_W-1:0] C_DELAY_LAST  = CNT_W'(REP_DELAY_T - 1);
  localparam logic [CNT_W-1:0] C_PERIOD_LAST = CNT_W'(REP_PERIOD_T - 1);

  logic             r_s1;
  logic             r_s0;
  logic             r_ux;
  logic [CNT_W-1:0] r_xf;
  logic             r_rise;
  logic             r_fall;
  logic             r_rep;
  rep_state_t       r_state;
  logic [CNT_W-1:0] r_rcnt;

  logic             w_ux_nxt;
  logic [CNT_W-1:0] w_xf_nxt;
  logic             w_rise;
  logic             w_fall;
  rep_state_t       w_state_nxt;
  logic [CNT_W-1:0] w_rcnt_nxt;
  logic             w_rep_pulse;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s0 <= 1'b0;
    end else begin
      r_s1 <= i_btn;
      r_s0 <= r_s1;
    end
  end

  // Any clock at the accepted level clears the count, so only an
  // unbroken run of HOLD_T disagreeing ticks flips the output.
  always_comb begin
    w_ux_nxt = r_ux;
    w_xf_nxt = r_xf;
    w_rise   = 1'b0;
    w_fall   = 1'b0;
    if (r_s0 == r_ux) begin
      w_xf_nxt = '0;
    end else if (i_tick && (r_xf == C_HOLD_LAST)) begin
      w_ux_nxt = r_s0;
      w_xf_nxt = '0;
      w_rise   = r_s0;
      w_fall   = ~r_s0;
    end else if (i_tick) begin
      w_xf_nxt = r_xf + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rcnt_nxt  = r_rcnt;
    w_rep_pulse = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rise && i_rep_en) begin
          w_state_nxt = S_DELAY;
          w_rcnt_nxt  = '0;
        end
      end
      S_DELAY: begin
        if (w_fall || !i_rep_en) begin
          w_state_nxt = S_IDLE;
          w_rcnt_nxt  = '0;
        end else if (i_tick) begin
          if (r_rcnt == C_DELAY_LAST) begin
            w_rep_pulse = 1'b1;
            w_rcnt_nxt  = '0;
            w_state_nxt = S_REPEAT;
          end else begin
            w_rcnt_nxt = r_rcnt + 1'b1;
          end
        end
      end
      S_REPEAT: begin
        if (w_fall || !i_rep_en) begin
          w_state_nxt = S_IDLE;
          w_rcnt_nxt  = '0;
        end else if (i_tick) begin
          if (r_rcnt == C_PERIOD_LAST) begin
            w_rep_pulse = 1'b1;
            w_rcnt_nxt  = '0;
          end else begin
            w_rcnt_nxt = r_rcnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_rcnt_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ux    <= 1'b0;
      r_xf    <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_rep   <= 1'b0;
      r_state <= S_IDLE;
      r_rcnt  <= '0;
    end else begin
      r_ux    <= w_ux_nxt;
      r_xf    <= w_xf_nxt;
      r_rise  <= w_rise;
      r_fall  <= w_fall;
      r_rep   <= w_rise | w_rep_pulse;
      r_state <= w_state_nxt;
      r_rcnt  <= w_rcnt_nxt;
    end
  end

  assign o_level = r_ux;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;
  assign o_rep   = r_rep;
  assign o_xf    = r_xf;

endmodule
`default_nettype wire

// File: rtl/btn_debounce_bank.sv
`default_nettype none
// +------------------------------------------------------------------+
// | btn_debounce_bank : shared tick generator feeding N_CH           |
// |                     independent button debounce channels         |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
module btn_debounce_bank
  import btn_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int F_CLK        = 50_000_000,
  parameter int TICK_US      = 1000,
  parameter int CNT_W        = 16,
  parameter int HOLD_T       = 20,
  parameter int REP_DELAY_T  = 500,
  parameter int REP_PERIOD_T = 100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       BTN,
  input  logic [N_CH-1:0]       rep_en,
  output logic                  ce1ms,
  output logic [N_CH-1:0]       Ux,
  output logic [N_CH-1:0]       Ux_rise,
  output logic [N_CH-1:0]       Ux_fall,
  output logic [N_CH-1:0]       Ux_rep,
  output logic [N_CH*CNT_W-1:0] Xf
);

  localparam int                TICK_DIV    = tick_div(F_CLK, TICK_US);
  localparam int                TCNT_W      = clog2(TICK_DIV);
  localparam logic [TCNT_W-1:0] C_TICK_LAST = TCNT_W'(TICK_DIV - 1);

  logic [TCNT_W-1:0] r_tcnt;
  logic              r_ce1ms;
  logic [TCNT_W-1:0] w_tcnt_nxt;
  logic [CNT_W-1:0]  w_xf [N_CH];

  assign w_tcnt_nxt = (r_tcnt == C_TICK_LAST) ? '0 : r_tcnt + 1'b1;

  // Strobe is registered from the next count so it coincides exactly
  // with the terminal count without a decode glitch on the output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tcnt  <= '0;
      r_ce1ms <= 1'b0;
    end else begin
      r_tcnt  <= w_tcnt_nxt;
      r_ce1ms <= (w_tcnt_nxt == C_TICK_LAST);
    end
  end

  assign ce1ms = r_ce1ms;

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
      debounce_ch #(
        .CNT_W       (CNT_W),
        .HOLD_T      (HOLD_T),
        .REP_DELAY_T (REP_DELAY_T),
        .REP_PERIOD_T(REP_PERIOD_T)
      ) u_ch (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (BTN[i]),
        .i_rep_en(rep_en[i]),
        .i_tick  (r_ce1ms),
        .o_level (Ux[i]),
        .o_rise  (Ux_rise[i]),
        .o_fall  (Ux_fall[i]),
        .o_rep   (Ux_rep[i]),
        .o_xf    (w_xf[i])
      );
      assign Xf[i*CNT_W +: CNT_W] = w_xf[i];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_btn_debounce_bank.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_btn_debounce_bank : directed bench with a strobe scoreboard   |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
module tb_btn_debounce_bank;

  localparam int N_CH  = 2;
  localparam int CNT_W = 16;

  logic                  clk;
  logic                  rst;
  logic [N_CH-1:0]       BTN;
  logic [N_CH-1:0]       rep_en;
  logic                  ce1ms;
  logic [N_CH-1:0]       Ux;
  logic [N_CH-1:0]       Ux_rise;
  logic [N_CH-1:0]       Ux_fall;
  logic [N_CH-1:0]       Ux_rep;
  logic [N_CH*CNT_W-1:0] Xf;

  btn_debounce_bank #(
    .N_CH        (N_CH),
    .F_CLK       (1_000_000),
    .TICK_US     (5),
    .CNT_W       (CNT_W),
    .HOLD_T      (4),
    .REP_DELAY_T (6),
    .REP_PERIOD_T(3)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .BTN    (BTN),
    .rep_en (rep_en),
    .ce1ms  (ce1ms),
    .Ux     (Ux),
    .Ux_rise(Ux_rise),
    .Ux_fall(Ux_fall),
    .Ux_rep (Ux_rep),
    .Xf     (Xf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] cyc;
    logic        ch;
    logic        rise;
    logic        fall;
    logic        rep;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc;

  // Edges since reset release; ticks are consumed on edges 5, 10, 15 ...
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic int next_tick(input int x);
    return ((x + 4) / 5) * 5;
  endfunction

  function automatic int ticks_between(input int lo, input int hi);
    if (hi < lo) return 0;
    return (hi / 5) - ((lo - 1) / 5);
  endfunction

  task automatic step;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_ev(input int c, input logic ch, input logic r, input logic f, input logic p);
    ev_t e;
    e.cyc  = c;
    e.ch   = ch;
    e.rise = r;
    e.fall = f;
    e.rep  = p;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every observed strobe must match the head of the queue.
  always @(negedge clk) begin
    ev_t obs;
    ev_t exp;
    if (!rst) begin
      while (exp_q.size() > 0 && int'(exp_q[0].cyc) < cyc) begin
        exp = exp_q.pop_front();
        obs = '0;
        checks++;
        assert (obs === exp) else begin
          errors++;
          $error("FAIL missed_strobe observed=%0h expected=%0h", obs, exp);
        end
      end
      for (int ch = 0; ch < N_CH; ch++) begin
        if (Ux_rise[ch] || Ux_fall[ch] || Ux_rep[ch]) begin
          obs.cyc  = cyc;
          obs.ch   = (ch == 1);
          obs.rise = Ux_rise[ch];
          obs.fall = Ux_fall[ch];
          obs.rep  = Ux_rep[ch];
          exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
          checks++;
          assert (obs === exp) else begin
            errors++;
            $error("FAIL strobe observed=%0h expected=%0h", obs, exp);
          end
        end
      end
    end
  end

  initial begin
    int c;
    int a;
    int a2;
    int mx;
    rst    = 1'b1;
    BTN    = '0;
    rep_en = '0;
    repeat (3) step();
    chk("rst_ce1ms", 32'(ce1ms), 0);
    chk("rst_ux", 32'(Ux), 0);
    chk("rst_xf", Xf, 0);
    chk("rst_strobes", 32'({Ux_rise, Ux_fall, Ux_rep}), 0);
    rst = 1'b0;

    // Tick generator
    for (int i = 0; i < 20; i++) begin
      step();
      chk("tick", 32'(ce1ms), 32'(cyc % 5 == 4));
    end

    // Clean press on channel 0
    c = cyc;
    BTN[0] = 1'b1;
    a = next_tick(c + 3) + 15;
    push_ev(a, 1'b0, 1'b1, 1'b0, 1'b1);
    while (cyc < a + 2) begin
      step();
      chk("press_xf0", Xf[0 +: CNT_W], (cyc < a) ? ticks_between(c + 3, cyc) : 0);
      chk("press_ux0", 32'(Ux[0]), 32'(cyc >= a));
      chk("press_ch1", Xf[CNT_W +: CNT_W] | 32'(Ux[1]), 0);
    end
    chk("press_q", exp_q.size(), 0);
    c = cyc;
    BTN[0] = 1'b0;
    a2 = next_tick(c + 3) + 15;
    push_ev(a2, 1'b0, 1'b0, 1'b1, 1'b0);
    while (cyc < a2 + 2) step();
    chk("release_ux0", 32'(Ux[0]), 0);
    chk("release_q", exp_q.size(), 0);

    // Glitch: high for 12 clocks, aligned so exactly two ticks land inside
    while (cyc % 5 != 3) step();
    c = cyc;
    BTN[0] = 1'b1;
    mx = 0;
    while (cyc < c + 12) begin
      step();
      if (int'(Xf[0 +: CNT_W]) > mx) mx = int'(Xf[0 +: CNT_W]);
    end
    chk("glitch_peak", mx, 2);
    BTN[0] = 1'b0;
    repeat (3) step();
    chk("glitch_clear", Xf[0 +: CNT_W], 0);
    chk("glitch_ux0", 32'(Ux[0]), 0);

    // Auto-repeat; release timed so fall coincides with a repeat tick
    rep_en[0] = 1'b1;
    c = cyc;
    BTN[0] = 1'b1;
    a = next_tick(c + 3) + 15;
    push_ev(a,      1'b0, 1'b1, 1'b0, 1'b1);
    push_ev(a + 30, 1'b0, 1'b0, 1'b0, 1'b1);
    push_ev(a + 45, 1'b0, 1'b0, 1'b0, 1'b1);
    push_ev(a + 60, 1'b0, 1'b0, 1'b0, 1'b1);
    while (cyc < a + 57) step();
    BTN[0] = 1'b0;
    push_ev(a + 75, 1'b0, 1'b0, 1'b1, 1'b0);
    while (cyc < a + 100) step();
    chk("repeat_q", exp_q.size(), 0);
    chk("repeat_ux0", 32'(Ux[0]), 0);

    // rep_en low: only the rise strobe during a 40-tick hold
    rep_en[0] = 1'b0;
    c = cyc;
    BTN[0] = 1'b1;
    a = next_tick(c + 3) + 15;
    push_ev(a, 1'b0, 1'b1, 1'b0, 1'b1);
    while (cyc < a + 200) step();
    chk("norep_q", exp_q.size(), 0);
    c = cyc;
    BTN[0] = 1'b0;
    push_ev(next_tick(c + 3) + 15, 1'b0, 1'b0, 1'b1, 1'b0);
    while (cyc < c + 30) step();

    // rep_en dropped on the same clock as the first repeat tick
    rep_en[0] = 1'b1;
    c = cyc;
    BTN[0] = 1'b1;
    a = next_tick(c + 3) + 15;
    push_ev(a, 1'b0, 1'b1, 1'b0, 1'b1);
    while (cyc < a + 29) step();
    rep_en[0] = 1'b0;
    while (cyc < a + 60) step();
    chk("repoff_q", exp_q.size(), 0);

    // Reset mid-count on channel 1 while channel 0 is held high
    c = cyc;
    BTN[1] = 1'b1;
    a = next_tick(c + 3) + 5;
    while (cyc < a) step();
    chk("mid_xf1", Xf[CNT_W +: CNT_W], 2);
    chk("mid_ux0", 32'(Ux[0]), 1);
    rst = 1'b1;
    #1;
    chk("async_xf", Xf, 0);
    chk("async_ux", 32'(Ux), 0);
    chk("async_strobes", 32'({Ux_rise, Ux_fall, Ux_rep, ce1ms}), 0);
    repeat (2) step();
    rst = 1'b0;
    while (cyc < 5) step();
    chk("resume_xf0", Xf[0 +: CNT_W], 1);
    chk("resume_xf1", Xf[CNT_W +: CNT_W], 1);
    push_ev(20, 1'b0, 1'b1, 1'b0, 1'b1);
    push_ev(20, 1'b1, 1'b1, 1'b0, 1'b1);
    while (cyc < 25) step();
    chk("resume_ux", 32'(Ux), 3);
    chk("resume_q", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
